// File: rtl/sinc_pkg.sv
// sinc_pkg -- shared widths, limits and the bitstream sign mapping for the sinc decimator.
// Rev 1.0
`default_nettype none

package sinc_pkg;

   localparam int MAX_ORDER    = 5;
   localparam int MAX_DEC_LOG2 = 8;

   // Bitstream level as seen by the integrators: 1 -> +1, 0 -> -1
   typedef enum logic {
      SAMPLE_NEG = 1'b0,
      SAMPLE_POS = 1'b1
   } sample_t;

   function automatic int cic_width(input int order, input int dec_log2);
      return order * dec_log2 + 2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sinc_decimator_if.sv
// sinc_decimator_if -- bitstream in / decimated words out bundle for the sinc decimator.
// Rev 1.0
`default_nettype none

interface sinc_decimator_if #(
   parameter int NCH   = 1,
   parameter int OUT_W = 14
);
   logic                 en;
   logic                 clr;
   logic [NCH-1:0]       din;
   logic [NCH*OUT_W-1:0] dout;
   logic                 valid;
   logic                 settled;

   modport master (output en, clr, din, input dout, valid, settled);
   modport slave  (input en, clr, din, output dout, valid, settled);
endinterface

`default_nettype wire

// File: rtl/sinc_channel.sv
// sinc_channel -- one channel's sinc^N integrator chain and tick-driven comb chain.
// Rev 1.0
`default_nettype none

module sinc_channel
   import sinc_pkg::*;
#(
   parameter int ORDER = 3,
   parameter int OUT_W = 14
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    x,
   input  logic                    en,
   input  logic                    tick,
   input  logic                    clr,
   output logic signed [OUT_W-1:0] dout
);

   logic signed [OUT_W-1:0] x_ext;
   logic signed [OUT_W-1:0] integ   [ORDER];
   logic signed [OUT_W-1:0] dly     [ORDER];
   logic signed [OUT_W-1:0] comb_in [ORDER];
   logic signed [OUT_W-1:0] comb_out;

   assign x_ext = (sample_t'(x) == SAMPLE_POS) ? OUT_W'(1) : '1;

   // Comb works on the pre-update last integrator; modular wrap cancels exactly here
   always_comb begin
      comb_out = integ[ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
         comb_in[k] = comb_out;
         comb_out   = comb_out - dly[k];
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int k = 0; k < ORDER; k++) begin
            integ[k] <= '0;
            dly[k]   <= '0;
         end
         dout <= '0;
      end else if (clr) begin
         for (int k = 0; k < ORDER; k++) begin
            integ[k] <= '0;
            dly[k]   <= '0;
         end
         dout <= '0;
      end else if (en) begin
         integ[0] <= integ[0] + x_ext;
         for (int k = 1; k < ORDER; k++) begin
            integ[k] <= integ[k] + integ[k-1];
         end
         if (tick) begin
            for (int k = 0; k < ORDER; k++) begin
               dly[k] <= comb_in[k];
            end
            dout <= comb_out;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/sinc_decimator.sv
// sinc_decimator -- NCH-channel sinc^N decimator (R = 2**DEC_LOG2) with settle masking.
// Rev 1.0
`default_nettype none

module sinc_decimator
   import sinc_pkg::*;
#(
   parameter int ORDER    = 3,
   parameter int DEC_LOG2 = 4,
   parameter int NCH      = 1
) (
   input  logic            CLK,
   input  logic            RST,
   sinc_decimator_if.slave bus
);

   localparam int OUT_W = cic_width(ORDER, DEC_LOG2);
   localparam int SW    = $clog2(ORDER + 1);
   localparam logic [SW-1:0]       SETTLE_MAX = SW'(ORDER);
   localparam logic [DEC_LOG2-1:0] CNT_LAST   = '1;

   logic [DEC_LOG2-1:0] cnt;
   logic [SW-1:0]       settle_cnt;
   logic [SW-1:0]       settle_nxt;
   logic                tick;
   logic                valid_reg;

   assign tick = bus.en & (cnt == CNT_LAST);

   always_comb begin
      settle_nxt = settle_cnt;
      if (tick && (settle_cnt != SETTLE_MAX)) begin
         settle_nxt = settle_cnt + 1'b1;
      end
   end

   // Outputs from the first ORDER-1 ticks still carry start-up transients, so valid is held off
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt        <= '0;
         settle_cnt <= '0;
         valid_reg  <= 1'b0;
      end else if (bus.clr) begin
         cnt        <= '0;
         settle_cnt <= '0;
         valid_reg  <= 1'b0;
      end else begin
         if (bus.en) begin
            cnt <= cnt + 1'b1;
         end
         settle_cnt <= settle_nxt;
         valid_reg  <= tick && (settle_nxt == SETTLE_MAX);
      end
   end

   assign bus.valid   = valid_reg;
   assign bus.settled = (settle_cnt == SETTLE_MAX);

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      sinc_channel #(
         .ORDER (ORDER),
         .OUT_W (OUT_W)
      ) u_ch (
         .CLK  (CLK),
         .RST  (RST),
         .x    (bus.din[k]),
         .en   (bus.en),
         .tick (tick),
         .clr  (bus.clr),
         .dout (bus.dout[k*OUT_W +: OUT_W])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_sinc_decimator.sv
// tb_sinc_decimator -- scoreboard bench for sinc_decimator (N=3, R=16, two channels).
// Rev 1.0
`default_nettype none

module tb_sinc_decimator;
   import sinc_pkg::*;

   localparam int ORDER    = 3;
   localparam int DEC_LOG2 = 4;
   localparam int NCH      = 2;
   localparam int R        = 1 << DEC_LOG2;
   localparam int W        = cic_width(ORDER, DEC_LOG2);

   typedef logic [NCH*W-1:0] word_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   sinc_decimator_if #(.NCH(NCH), .OUT_W(W)) bus ();

   sinc_decimator #(
      .ORDER    (ORDER),
      .DEC_LOG2 (DEC_LOG2),
      .NCH      (NCH)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int    n_checks = 0;
   int    n_pass   = 0;
   word_t exp_q[$];
   bit    s0[$];
   bit    s1[$];
   int    b_cnt    = 0;
   int    b_settle = 0;
   int    cyc      = 0;
   int    last_valid_cyc = 0;
   int    valid_gap      = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic longint binom(input longint a, input int b);
      longint r;
      if (a < b) return 0;
      r = 1;
      for (int i = 0; i < b; i++) r = r * (a - i) / (i + 1);
      return r;
   endfunction

   // Direct-form reference: last integrator after m samples = sum s_j * C(m-1-j, N-1)
   function automatic longint integ_n(input bit s[$], input int m);
      longint acc = 0;
      for (int j = 0; j < m; j++)
         acc += (s[j] ? 64'sd1 : -64'sd1) * binom(m - 1 - j, ORDER - 1);
      return acc;
   endfunction

   function automatic longint model_out(input bit s[$]);
      longint acc = 0;
      int     m   = s.size();
      for (int l = 0; l <= ORDER; l++) begin
         if (m - l * R >= 0)
            acc += ((l % 2) ? -64'sd1 : 64'sd1) * binom(ORDER, l) * integ_n(s, m - l * R);
      end
      return acc;
   endfunction

   task automatic model_clear();
      s0.delete();
      s1.delete();
      b_cnt    = 0;
      b_settle = 0;
   endtask

   task automatic step(input bit e, input bit c, input bit d0, input bit d1);
      bus.en  = e;
      bus.clr = c;
      bus.din = {d1, d0};
      @(posedge CLK);
      if (c) begin
         model_clear();
      end else if (e) begin
         if (b_cnt == R - 1) begin
            if (b_settle < ORDER) b_settle++;
            if (b_settle == ORDER)
               exp_q.push_back({W'(model_out(s1)), W'(model_out(s0))});
         end
         s0.push_back(d0);
         s1.push_back(d1);
         b_cnt = (b_cnt + 1) % R;
      end
      #1;
   endtask

   task automatic check_idle_state(input string tag);
      check({tag, "_dout0"},   $signed(bus.dout[W-1:0]), 0);
      check({tag, "_dout1"},   $signed(bus.dout[2*W-1:W]), 0);
      check({tag, "_valid"},   bus.valid, 0);
      check({tag, "_settled"}, bus.settled, 0);
   endtask

   task automatic check_full_scale(input string tag, input longint e0, input longint e1);
      check({tag, "_dout0"}, $signed(bus.dout[W-1:0]), e0);
      check({tag, "_dout1"}, $signed(bus.dout[2*W-1:W]), e1);
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: every valid strobe must match the oldest outstanding expectation
   always @(negedge CLK) begin
      word_t w;
      if (RST && bus.valid) begin
         valid_gap      = cyc - last_valid_cyc;
         last_valid_cyc = cyc;
         if (exp_q.size() == 0) begin
            check("valid_without_tick", bus.valid, 0);
         end else begin
            w = exp_q.pop_front();
            check("sb_dout0", $signed(bus.dout[W-1:0]), $signed(w[W-1:0]));
            check("sb_dout1", $signed(bus.dout[2*W-1:W]), $signed(w[2*W-1:W]));
            check("sb_settled", bus.settled, 1);
         end
      end
   end

   initial begin
      bus.en  = 1'b0;
      bus.clr = 1'b0;
      bus.din = '0;
      repeat (3) @(posedge CLK);
      #1;
      check_idle_state("reset");
      RST = 1'b1;
      model_clear();

      // Constant +1 / -1: settles on tick 3, full scale +/-R^3
      for (int i = 0; i < 2 * R; i++) step(1, 0, 1, 0);
      check("settled_after_2_ticks", bus.settled, 0);
      for (int i = 0; i < R; i++) step(1, 0, 1, 0);
      check("settled_after_3_ticks", bus.settled, 1);
      for (int i = 0; i < 3 * R; i++) step(1, 0, 1, 0);
      check_full_scale("const", 4096, -4096);

      // Alternating bitstream averages to exactly zero
      step(0, 1, 0, 0);
      for (int i = 0; i < 6 * R; i++) step(1, 0, (i % 2) == 0, (i % 2) != 0);
      check_full_scale("alt", 0, 0);

      // en toggling every cycle stretches the tick period to 2R
      step(0, 1, 0, 0);
      for (int i = 0; i < 12 * 2 * R; i++) step((i % 2) == 0, 0, 1, 0);
      check("en_toggle_tick_gap", valid_gap, 2 * R);
      check_full_scale("en_toggle", 4096, -4096);

      // Random bitstream with sparse en gaps; integrators wrap many times
      step(0, 1, 0, 0);
      for (int i = 0; i < 5000; i++)
         step($urandom_range(0, 7) != 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("random_drained", exp_q.size(), 0);

      // Async reset mid-frame at cnt=7
      step(0, 1, 0, 0);
      for (int i = 0; i < 3 * R + 7; i++) step(1, 0, 1, 0);
      check("pre_rst_cnt", b_cnt, 7);
      @(negedge CLK);
      #1;
      RST = 1'b0;
      model_clear();
      #1;
      check_idle_state("async_rst");
      @(posedge CLK);
      #1;
      RST = 1'b1;
      for (int i = 0; i < 3 * R; i++) step(1, 0, 1, 0);
      check("post_rst_3_ticks_settled", bus.settled, 1);
      for (int i = 0; i < 2 * R; i++) step(1, 0, 1, 0);
      check_full_scale("post_rst", 4096, -4096);

      // clr with en=1 mid-frame: clr wins and the sample is dropped
      step(0, 1, 0, 0);
      for (int i = 0; i < 20; i++) step(1, 0, 1, 0);
      step(1, 1, 1, 0);
      check_idle_state("clr_with_en");
      for (int i = 0; i < 5 * R; i++) step(1, 0, 1, 0);
      check_full_scale("post_clr", 4096, -4096);

      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
